prio_arbiter_rr: RTL and testbench

- Parametrised, registered N-way arbiter; successor to the combinational 8:3 priority encoder.
- Picks one requester and drives a one-hot grant plus a binary index and valid flag.
- Holds the grant until the owner releases it or a hold-time limit preempts it.
- Supports fixed MSB-first priority or round-robin, selected at run time. Sits in front of shared resources (bus, memory port) that more than one master requests.

---
 rtl/prio_arbiter_rr.sv | 128 ++++++++++++
 tb/tb_prio_arbiter_rr.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/prio_arbiter_rr.sv
// Registered N-way arbiter. Priority is fixed MSB-first or round-robin, and a hold-time limit can preempt the owner.
// Latency: a sampled request becomes a visible grant one clock later. There is always one idle cycle between grants.
// Backpressure: none. A requester holds req until it is granted, then drops req to release the resource.
module prio_arbiter_rr #(
  parameter int  N        = 8,
  parameter int  MAX_HOLD = 0,
  localparam int IDX_W    = $clog2(N),
  localparam int HOLD_W   = $clog2(MAX_HOLD + 2)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  input  logic             en,
  input  logic             mode,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_valid,
  output logic             preempt
);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t            state, state_nxt;
  logic [N-1:0]      gnt_nxt;
  logic [IDX_W-1:0]  idx_nxt;
  logic              valid_nxt;
  logic              preempt_nxt;
  logic [IDX_W-1:0]  rr_ptr, rr_ptr_nxt;
  logic [HOLD_W-1:0] hold_cnt, hold_nxt;

  logic [IDX_W-1:0]  fix_win, rr_lo_all, rr_lo_ge, win, owner_inc;
  logic              rr_ge_found;
  logic              hold_at_max, others_pending, owner_req;

  // Compute the winner candidate for each mode from the live request vector.
  always_comb begin
    fix_win     = '0;
    rr_lo_all   = '0;
    rr_lo_ge    = '0;
    rr_ge_found = 1'b0;
    // The scan runs upward, so the last hit is the highest set index.
    for (int i = 0; i < N; i++) begin
      if (req[i]) fix_win = IDX_W'(i);
    end
    // The scan runs downward, so the last hit is the lowest set index.
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) rr_lo_all = IDX_W'(i);
      if (req[i] && (IDX_W'(i) >= rr_ptr)) begin
        rr_lo_ge    = IDX_W'(i);
        rr_ge_found = 1'b1;
      end
    end
    win = mode ? (rr_ge_found ? rr_lo_ge : rr_lo_all) : fix_win;
  end

  // Derive the conditions that control how the current owner's grant ends.
  always_comb begin
    owner_req      = req[gnt_idx];
    others_pending = |(req & ~gnt);
    hold_at_max    = (MAX_HOLD != 0) && (hold_cnt == HOLD_W'(MAX_HOLD));
    owner_inc      = (gnt_idx == IDX_W'(N - 1)) ? '0 : gnt_idx + IDX_W'(1);
  end

  // Next-state and next-output logic. The outputs are registered, so this only decides what they become.
  always_comb begin
    state_nxt   = state;
    gnt_nxt     = gnt;
    idx_nxt     = gnt_idx;
    valid_nxt   = gnt_valid;
    preempt_nxt = 1'b0;
    rr_ptr_nxt  = rr_ptr;
    hold_nxt    = hold_cnt;
    case (state)
      IDLE: begin
        gnt_nxt   = '0;
        idx_nxt   = '0;
        valid_nxt = 1'b0;
        hold_nxt  = '0;
        if (en && (|req)) begin
          state_nxt = GRANT;
          for (int i = 0; i < N; i++) begin
            gnt_nxt[i] = (IDX_W'(i) == win);
          end
          idx_nxt   = win;
          valid_nxt = 1'b1;
          hold_nxt  = HOLD_W'(1);
        end
      end
      GRANT: begin
        // A release takes precedence: preempt is raised only while the owner still requests.
        if (!owner_req || (hold_at_max && others_pending)) begin
          state_nxt   = IDLE;
          gnt_nxt     = '0;
          idx_nxt     = '0;
          valid_nxt   = 1'b0;
          hold_nxt    = '0;
          rr_ptr_nxt  = owner_inc;
          preempt_nxt = owner_req;
        end else if ((MAX_HOLD != 0) && !hold_at_max) begin
          hold_nxt = hold_cnt + HOLD_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State and output registers, with an asynchronous reset to a cleared IDLE state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      gnt       <= '0;
      gnt_idx   <= '0;
      gnt_valid <= 1'b0;
      preempt   <= 1'b0;
      rr_ptr    <= '0;
      hold_cnt  <= '0;
    end else begin
      state     <= state_nxt;
      gnt       <= gnt_nxt;
      gnt_idx   <= idx_nxt;
      gnt_valid <= valid_nxt;
      preempt   <= preempt_nxt;
      rr_ptr    <= rr_ptr_nxt;
      hold_cnt  <= hold_nxt;
    end
  end

endmodule

// File: tb/tb_prio_arbiter_rr.sv
// Bench for prio_arbiter_rr: directed scenarios followed by randomized traffic, checked against a cycle model.
// The model tracks the owner, the consecutive cycles held, and the next round-robin start as plain integers.
// Inputs change 1ns after each rising edge, and outputs are compared 1ns after each rising edge.
module tb_prio_arbiter_rr;
  localparam int N        = 8;
  localparam int MAX_HOLD = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] req;
  logic         en;
  logic         mode;
  logic [N-1:0] gnt;
  logic [2:0]   gnt_idx;
  logic         gnt_valid;
  logic         preempt;

  int tests_run    = 0;
  int tests_failed = 0;

  // Model state. m_owner is -1 when no grant is held.
  int m_owner;
  int m_held;
  int m_next;
  bit m_preempt;

  always #5 clk = ~clk;

  prio_arbiter_rr #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
    .clk(clk), .rst(rst), .req(req), .en(en), .mode(mode),
    .gnt(gnt), .gnt_idx(gnt_idx), .gnt_valid(gnt_valid), .preempt(preempt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // In fixed mode the highest index wins. In round-robin mode the winner is the first set bit
  // found when walking upward from the start pointer and wrapping around.
  function automatic int pick(input logic [N-1:0] r, input bit md, input int start);
    if (md == 1'b0) begin
      for (int i = N - 1; i >= 0; i--) if (r[i]) return i;
    end else begin
      for (int k = 0; k < N; k++) if (r[(start + k) % N]) return (start + k) % N;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_owner   = -1;
    m_held    = 0;
    m_next    = 0;
    m_preempt = 1'b0;
  endtask

  // Advance the model by one rising edge, using the inputs sampled at that edge.
  task automatic model_edge();
    logic [N-1:0] others;
    m_preempt = 1'b0;
    if (m_owner < 0) begin
      if (en && (req != '0)) begin
        m_owner = pick(req, mode, m_next);
        m_held  = 1;
      end
    end else begin
      others = req;
      others[m_owner] = 1'b0;
      if (!req[m_owner]) begin
        m_next  = (m_owner + 1) % N;
        m_owner = -1;
      end else if (m_held >= MAX_HOLD && others != '0) begin
        m_next    = (m_owner + 1) % N;
        m_owner   = -1;
        m_preempt = 1'b1;
      end else begin
        m_held++;
      end
    end
  endtask

  task automatic compare_model(input string tag);
    logic [N-1:0] e_gnt;
    e_gnt = '0;
    if (m_owner >= 0) e_gnt[m_owner] = 1'b1;
    check({tag, "/gnt"},     32'(gnt),       32'(e_gnt));
    check({tag, "/idx"},     32'(gnt_idx),   (m_owner >= 0) ? 32'(m_owner) : 32'd0);
    check({tag, "/valid"},   32'(gnt_valid), (m_owner >= 0) ? 32'd1 : 32'd0);
    check({tag, "/preempt"}, 32'(preempt),   32'(m_preempt));
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    compare_model(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst  = 1'b1;
    req  = '0;
    en   = 1'b0;
    mode = 1'b0;
    model_reset();
    #12;
    compare_model("reset");
    rst = 1'b0;

    // Fixed priority: requests 6, 5 and 2 are pending, and 6 wins.
    mode = 1'b0; en = 1'b1; req = 8'b0110_0100;
    step("fixed");
    check("fixed_idx", 32'(gnt_idx), 32'd6);
    check("fixed_gnt", 32'(gnt), 32'h40);
    step("fixed_hold");
    step("fixed_hold");
    check("fixed_hold_idx", 32'(gnt_idx), 32'd6);
    req = '0;
    step("fixed_rel");

    // The owner releases: one idle cycle, then the remaining requester is granted.
    req = 8'b1000_0001;
    step("rel_a");
    check("rel_idx7", 32'(gnt_idx), 32'd7);
    req = 8'h01;
    step("rel_b");
    check("rel_gap_valid", 32'(gnt_valid), 32'd0);
    step("rel_c");
    check("rel_idx0", 32'(gnt_idx), 32'd0);
    req = '0;
    step("rel_d");

    // Round-robin with every requester active: each grant is cut off by the hold limit.
    mode = 1'b1; req = 8'hFF;
    for (int c = 0; c < 45; c++) step("rr_ff");
    req = '0;
    step("rr_ff_end");
    step("rr_ff_end");

    // A lone requester keeps its grant past the hold limit. A second requester then forces a preemption.
    req = 8'h08;
    for (int c = 0; c < 10; c++) step("lone");
    check("lone_idx", 32'(gnt_idx), 32'd3);
    check("lone_nopre", 32'(preempt), 32'd0);
    req = 8'h28;
    step("lone_pre");
    check("lone_pre_flag", 32'(preempt), 32'd1);
    check("lone_pre_valid", 32'(gnt_valid), 32'd0);
    step("lone_next");
    check("lone_next_idx", 32'(gnt_idx), 32'd5);
    req = '0;
    step("lone_end");

    // Enable and mode gating.
    en = 1'b0; mode = 1'b0; req = 8'hFF;
    for (int c = 0; c < 3; c++) step("en_off");
    check("en_off_valid", 32'(gnt_valid), 32'd0);
    en = 1'b1;
    step("gate_grant");
    check("gate_idx7", 32'(gnt_idx), 32'd7);
    mode = 1'b1;
    step("gate_mode_chg");
    check("gate_owner_kept", 32'(gnt_idx), 32'd7);
    req = 8'h7F;
    step("gate_rel");
    step("gate_rr");
    check("gate_rr_idx0", 32'(gnt_idx), 32'd0);
    req = '0;
    step("gate_end");

    // An asynchronous reset in the middle of a grant. Afterwards the round-robin start must be back at 0.
    req = 8'h20;
    step("rst_grant");
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    compare_model("rst_async");
    check("rst_async_gnt", 32'(gnt), 32'd0);
    #1;
    rst = 1'b0;
    req = 8'h81; mode = 1'b1; en = 1'b1;
    step("rst_after");
    check("rst_ptr_idx0", 32'(gnt_idx), 32'd0);
    req = '0;
    step("rst_end");

    // Randomized traffic. Requests are kept stable over stretches so that holds, releases and preemptions all occur.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 3) == 0) begin
        case ($urandom_range(0, 3))
          0:       req = N'($urandom);
          1:       req = N'($urandom & $urandom);
          2:       req = N'(1 << $urandom_range(0, N - 1));
          default: req = '0;
        endcase
      end
      en   = ($urandom_range(0, 7) != 0);
      mode = 1'($urandom_range(0, 1));
      step("rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
